// File: rtl/adc_intf_pkg.sv
// Shared definitions for the serial ADC front ends: one-hot FSM encoding and a width helper.
package adc_intf_pkg;

    localparam int unsigned IDLE_BIT  = 0;
    localparam int unsigned CONV_BIT  = 1;
    localparam int unsigned QUIET_BIT = 2;
    localparam int unsigned HOLD_BIT  = 3;

    localparam logic [3:0] ST_IDLE  = 4'(1 << IDLE_BIT);
    localparam logic [3:0] ST_CONV  = 4'(1 << CONV_BIT);
    localparam logic [3:0] ST_QUIET = 4'(1 << QUIET_BIT);
    localparam logic [3:0] ST_HOLD  = 4'(1 << HOLD_BIT);

    // Bits needed to hold values 0..value-1; never less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/adc_multi_serial_intf_if.sv
// Request/result handshake between the sample scheduler/consumer and the ADC front end.
interface adc_multi_serial_intf_if #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned DATA_W = 12
);
    logic                    adc_start;
    logic                    adc_slow;
    logic                    adc_ready;
    logic [NCH*DATA_W-1:0]   adc_data;
    logic                    adc_data_val;
    logic                    adc_data_ack;

    modport master (
        output adc_start, adc_slow, adc_data_ack,
        input  adc_ready, adc_data, adc_data_val
    );

    modport slave (
        input  adc_start, adc_slow, adc_data_ack,
        output adc_ready, adc_data, adc_data_val
    );
endinterface

// File: rtl/adc_sclk_gen.sv
// SCLK divider: 50% duty clock with selectable period, plus fall and period-end strobes.
module adc_sclk_gen
    import adc_intf_pkg::*;
#(
    parameter int unsigned FAST_DIV = 4,
    parameter int unsigned SLOW_DIV = 32
) (
    input  logic tx_clk,
    input  logic tx_rst_n,
    input  logic run,
    input  logic div_sel,
    output logic sclk,
    output logic fall_stb,
    output logic period_end
);
    localparam int unsigned CW = clog2(SLOW_DIV);

    localparam logic [CW-1:0] FAST_LAST = CW'(FAST_DIV - 1);
    localparam logic [CW-1:0] FAST_HALF = CW'(FAST_DIV / 2);
    localparam logic [CW-1:0] FAST_HM1  = CW'(FAST_DIV / 2 - 1);
    localparam logic [CW-1:0] SLOW_LAST = CW'(SLOW_DIV - 1);
    localparam logic [CW-1:0] SLOW_HALF = CW'(SLOW_DIV / 2);
    localparam logic [CW-1:0] SLOW_HM1  = CW'(SLOW_DIV / 2 - 1);

    if ((FAST_DIV % 2) != 0 || FAST_DIV < 2) begin : g_bad_fast
        $error("FAST_DIV must be even and >= 2");
    end
    if ((SLOW_DIV % 2) != 0 || SLOW_DIV <= FAST_DIV) begin : g_bad_slow
        $error("SLOW_DIV must be even and greater than FAST_DIV");
    end

    logic [CW-1:0] div_cnt;
    logic [CW-1:0] cnt_last;
    logic [CW-1:0] cnt_half;
    logic [CW-1:0] cnt_hm1;
    logic          at_last;

    // Select the terminal/half-period counts for the latched mode
    always_comb begin
        cnt_last = div_sel ? SLOW_LAST : FAST_LAST;
        cnt_half = div_sel ? SLOW_HALF : FAST_HALF;
        cnt_hm1  = div_sel ? SLOW_HM1  : FAST_HM1;
    end

    assign at_last    = (div_cnt == cnt_last);
    assign period_end = run & at_last;
    assign fall_stb   = run & (div_cnt == cnt_half);

    // Period counter; sclk is registered one count ahead so it is high exactly while div_cnt < DIV/2
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
        end else begin
            if (!run || at_last) div_cnt <= '0;
            else                 div_cnt <= div_cnt + CW'(1);
            sclk <= !run || at_last || (div_cnt < cnt_hm1);
        end
    end

endmodule

// File: rtl/adc_multi_serial_intf.sv
// Shared SCLK/CS_n front end for NCH AD727x-style ADCs, captured in parallel and held until acked.
module adc_multi_serial_intf
    import adc_intf_pkg::*;
#(
    parameter int unsigned NCH        = 2,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned LEAD_Z     = 2,
    parameter int unsigned FRAME_BITS = 16,
    parameter int unsigned FAST_DIV   = 4,
    parameter int unsigned SLOW_DIV   = 32,
    parameter int unsigned QUIET_CYC  = 4
) (
    input  logic                   tx_clk,
    input  logic                   tx_rst_n,
    adc_multi_serial_intf_if.slave bus,
    input  logic [NCH-1:0]         adc_sdin,
    output logic                   adc_clk,
    output logic                   adc_cs_n
);
    localparam int unsigned BW = clog2(FRAME_BITS + 1);
    localparam int unsigned QW = clog2(QUIET_CYC);

    localparam logic [BW-1:0] WIN_LO     = BW'(LEAD_Z);
    localparam logic [BW-1:0] WIN_HI     = BW'(LEAD_Z + DATA_W);
    localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME_BITS - 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYC - 1);

    if (LEAD_Z + DATA_W > FRAME_BITS) begin : g_bad_frame
        $error("LEAD_Z + DATA_W must not exceed FRAME_BITS");
    end
    if (NCH < 1 || QUIET_CYC < 1) begin : g_bad_cfg
        $error("NCH and QUIET_CYC must be at least 1");
    end

    logic [3:0]            state;
    logic                  mode;
    logic [BW-1:0]         bit_cnt;
    logic [QW-1:0]         quiet_cnt;
    logic [NCH*DATA_W-1:0] shift_flat;
    logic [NCH*DATA_W-1:0] data_q;
    logic                  sclk;
    logic                  fall_stb;
    logic                  period_end;
    logic                  start_acc;
    logic                  capture;

    assign start_acc = state[IDLE_BIT] & bus.adc_start;
    assign capture   = fall_stb && (bit_cnt >= WIN_LO) && (bit_cnt < WIN_HI);

    adc_sclk_gen #(
        .FAST_DIV (FAST_DIV),
        .SLOW_DIV (SLOW_DIV)
    ) u_sclk (
        .tx_clk     (tx_clk),
        .tx_rst_n   (tx_rst_n),
        .run        (state[CONV_BIT]),
        .div_sel    (mode),
        .sclk       (sclk),
        .fall_stb   (fall_stb),
        .period_end (period_end)
    );

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DATA_W-1:0] shreg;

        // MSB-first capture of this channel on in-window SCLK falls
        always_ff @(posedge tx_clk or negedge tx_rst_n) begin
            if (!tx_rst_n)      shreg <= '0;
            else if (start_acc) shreg <= '0;
            else if (capture)   shreg <= (shreg << 1) | DATA_W'(adc_sdin[i]);
        end

        assign shift_flat[i*DATA_W +: DATA_W] = shreg;
    end

    // Frame sequencing: IDLE -> CONV -> QUIET -> HOLD -> IDLE
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state     <= ST_IDLE;
            mode      <= 1'b0;
            bit_cnt   <= '0;
            quiet_cnt <= '0;
            data_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.adc_start) begin
                        state   <= ST_CONV;
                        mode    <= bus.adc_slow;
                        bit_cnt <= '0;
                    end
                end
                ST_CONV: begin
                    if (period_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            state     <= ST_QUIET;
                            quiet_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                ST_QUIET: begin
                    if (quiet_cnt == QUIET_LAST) begin
                        state  <= ST_HOLD;
                        data_q <= shift_flat;
                    end else begin
                        quiet_cnt <= quiet_cnt + QW'(1);
                    end
                end
                ST_HOLD: begin
                    if (bus.adc_data_ack) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs come straight from flops: one-hot state bits, data register, SCLK register
    assign bus.adc_ready    = state[IDLE_BIT];
    assign bus.adc_data_val = state[HOLD_BIT];
    assign bus.adc_data     = data_q;
    assign adc_cs_n         = ~state[CONV_BIT];
    assign adc_clk          = sclk;

endmodule

// File: tb/tb_adc_multi_serial_intf.sv
// Directed bench for adc_multi_serial_intf with a behavioural two-channel ADC model.
module tb_adc_multi_serial_intf;

    logic        tx_clk;
    logic        tx_rst_n;
    logic [1:0]  adc_sdin;
    logic        adc_clk;
    logic        adc_cs_n;

    adc_multi_serial_intf_if #(.NCH(2), .DATA_W(12)) bus ();

    adc_multi_serial_intf #(
        .NCH        (2),
        .DATA_W     (12),
        .LEAD_Z     (2),
        .FRAME_BITS (16),
        .FAST_DIV   (4),
        .SLOW_DIV   (32),
        .QUIET_CYC  (4)
    ) dut (
        .tx_clk   (tx_clk),
        .tx_rst_n (tx_rst_n),
        .bus      (bus),
        .adc_sdin (adc_sdin),
        .adc_clk  (adc_clk),
        .adc_cs_n (adc_cs_n)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] fw [2];
    int          mk    = 0;
    logic        mprev = 1'b1;
    bit          mon_en = 1'b0;
    int          hi_run = 0;

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    // ADC model: frame bit k (MSB of fw first) is driven for the whole SCLK period k
    always @(posedge tx_clk) begin
        #2;
        if (adc_cs_n) mk = 0;
        else if (adc_clk && !mprev) mk++;
        mprev = adc_clk;
        for (int ch = 0; ch < 2; ch++)
            adc_sdin[ch] = (mk < 16) ? fw[ch][15 - mk] : 1'b0;
    end

    // CS_n must stay high for at least QUIET_CYC+1 cycles between frames
    always @(posedge tx_clk) begin
        #1;
        if (adc_cs_n) hi_run++;
        else begin
            if (mon_en && hi_run != 0) check("cs_gap_ge5", 64'(hi_run >= 5), 64'd1);
            hi_run = 0;
        end
    end

    task automatic run_frame(input bit slow, input logic [11:0] d0, input logic [11:0] d1,
                             input bit lead_ones);
        int div, n, low, falls, sclk_low;
        logic prev;
        div   = slow ? 32 : 4;
        fw[0] = lead_ones ? {2'b11, d0, 2'b11} : {2'b00, d0, 2'b00};
        fw[1] = lead_ones ? {2'b11, d1, 2'b11} : {2'b00, d1, 2'b00};
        check("start_ready", 64'(bus.adc_ready), 64'd1);
        bus.adc_slow  = slow;
        bus.adc_start = 1'b1;
        tick();
        bus.adc_start = 1'b0;
        bus.adc_slow  = ~slow;
        check("first_conv_sclk_high", 64'(adc_clk), 64'd1);
        n = 1; low = 0; falls = 0; sclk_low = 0; prev = 1'b1;
        while (!bus.adc_data_val && n < 1200) begin
            if (!adc_cs_n) begin
                low++;
                if (!adc_clk) sclk_low++;
                if (prev && !adc_clk) falls++;
            end
            prev = adc_clk;
            bus.adc_start    = (n == 10);
            bus.adc_data_ack = (n == 20);
            tick();
            n++;
        end
        bus.adc_start    = 1'b0;
        bus.adc_data_ack = 1'b0;
        check("latency", 64'(n), 64'(1 + 16 * div + 4));
        check("cs_low_cycles", 64'(low), 64'(16 * div));
        check("sclk_falls", 64'(falls), 64'd16);
        check("sclk_low_cycles", 64'(sclk_low), 64'(8 * div));
        check("data", 64'(bus.adc_data), 64'({d1, d0}));
        check("ready_in_hold", 64'(bus.adc_ready), 64'd0);
    endtask

    task automatic ack_frame();
        bus.adc_data_ack = 1'b1;
        tick();
        bus.adc_data_ack = 1'b0;
        check("ack_ready", 64'(bus.adc_ready), 64'd1);
        check("ack_val", 64'(bus.adc_data_val), 64'd0);
    endtask

    initial begin
        int n, falls;
        logic prev;
        logic [11:0] r0, r1;
        bit rs;

        tx_rst_n         = 1'b0;
        bus.adc_start    = 1'b0;
        bus.adc_slow     = 1'b0;
        bus.adc_data_ack = 1'b0;
        fw[0] = '0;
        fw[1] = '0;
        repeat (3) @(posedge tx_clk);
        #1;
        check("rst_ready", 64'(bus.adc_ready), 64'd1);
        check("rst_sclk", 64'(adc_clk), 64'd1);
        check("rst_cs_n", 64'(adc_cs_n), 64'd1);
        check("rst_data", 64'(bus.adc_data), 64'd0);
        check("rst_val", 64'(bus.adc_data_val), 64'd0);
        tx_rst_n = 1'b1;
        tick();

        // Fast frame with reference data
        run_frame(1'b0, 12'hA5C, 12'h3F1, 1'b0);

        // Hold without ack, start pulses ignored, then ack+start together
        for (int c = 0; c < 8; c++) begin
            bus.adc_start = (c % 3 == 1);
            tick();
            check("hold_val", 64'(bus.adc_data_val), 64'd1);
            check("hold_data", 64'(bus.adc_data), 64'h3F1A5C);
            check("hold_cs_n", 64'(adc_cs_n), 64'd1);
        end
        bus.adc_start    = 1'b1;
        bus.adc_data_ack = 1'b1;
        tick();
        bus.adc_start    = 1'b0;
        bus.adc_data_ack = 1'b0;
        check("ackstart_ready", 64'(bus.adc_ready), 64'd1);
        check("ackstart_val", 64'(bus.adc_data_val), 64'd0);
        check("ackstart_data_kept", 64'(bus.adc_data), 64'h3F1A5C);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("no_new_frame_cs_n", 64'(adc_cs_n), 64'd1);
            check("no_new_frame_ready", 64'(bus.adc_ready), 64'd1);
        end

        // Slow frame
        run_frame(1'b1, 12'hFFF, 12'h001, 1'b0);
        ack_frame();

        // Reset at the 7th SCLK fall of a fast frame
        fw[0] = {2'b00, 12'h5A5, 2'b00};
        fw[1] = {2'b00, 12'h0F0, 2'b00};
        bus.adc_slow  = 1'b0;
        bus.adc_start = 1'b1;
        tick();
        bus.adc_start = 1'b0;
        falls = 0; prev = 1'b1; n = 0;
        while (falls < 7 && n < 100) begin
            if (prev && !adc_clk) falls++;
            prev = adc_clk;
            if (falls < 7) tick();
            n++;
        end
        check("rst_fall7_seen", 64'(falls), 64'd7);
        check("pre_rst_cs_n", 64'(adc_cs_n), 64'd0);
        #2 tx_rst_n = 1'b0;
        #1;
        check("midrst_cs_n", 64'(adc_cs_n), 64'd1);
        check("midrst_sclk", 64'(adc_clk), 64'd1);
        check("midrst_val", 64'(bus.adc_data_val), 64'd0);
        check("midrst_data", 64'(bus.adc_data), 64'd0);
        check("midrst_ready", 64'(bus.adc_ready), 64'd1);
        @(posedge tx_clk);
        #1;
        tx_rst_n = 1'b1;
        tick();
        run_frame(1'b0, 12'h5A5, 12'h0F0, 1'b0);
        ack_frame();

        // Ones in leading-zero and tail positions must not leak into the result
        run_frame(1'b0, 12'h000, 12'h123, 1'b1);
        ack_frame();

        // Back-to-back random frames with random mode
        mon_en = 1'b1;
        for (int f = 0; f < 100; f++) begin
            r0 = 12'($urandom);
            r1 = 12'($urandom);
            rs = 1'($urandom_range(0, 1));
            run_frame(rs, r0, r1, 1'b0);
            ack_frame();
        end
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
